// File: rtl/spi_ram_pkg.sv
// Shared command encoding and field positions for the SPI-attached byte RAM.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam int CMD_MSB = 9;
    localparam int CMD_LSB = 8;

endpackage

// File: rtl/spi_ram_array.sv
// MEM_DEPTH x 8 storage: synchronous write, registered read.
// Only the read register is reset; the array itself is never initialised.
module spi_ram_array
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [7:0]           wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [7:0]           rdata
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata holds between reads, which is what keeps dout stable for the SPI slave
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/spi_ram.sv
// Byte RAM behind the SPI slave: decodes 10-bit command words on rising rx_valid.
// Optional macro SPI_RAM_AUTOINC_EN: successful data commands post-increment their address.
module spi_ram
    import spi_ram_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    logic                 rx_valid_q;
    logic                 accept;
    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] addr_field;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 wr_addr_set;
    logic                 rd_addr_set;
    logic                 mem_we;
    logic                 mem_re;

    assign accept     = rx_valid && !rx_valid_q;
    assign cmd        = din[CMD_MSB:CMD_LSB];
    assign addr_field = din[ADDR_SIZE-1:0];

    // Gated by rst_n so a command coinciding with the reset edge cannot touch the array
    assign mem_we = rst_n && accept && (cmd == CMD_WR_DATA) && wr_addr_set;
    assign mem_re = rst_n && accept && (cmd == CMD_RD_DATA) && rd_addr_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_q  <= 1'b0;
            tx_valid    <= 1'b0;
            cmd_err     <= 1'b0;
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_set <= 1'b0;
            rd_addr_set <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            tx_valid   <= 1'b0;
            cmd_err    <= 1'b0;
            if (accept) begin
                case (cmd)
                    CMD_WR_ADDR: begin
                        wr_addr     <= addr_field;
                        wr_addr_set <= 1'b1;
                    end
                    CMD_WR_DATA: begin
                        cmd_err <= !wr_addr_set;
`ifdef SPI_RAM_AUTOINC_EN
                        if (wr_addr_set) begin
                            wr_addr <= wr_addr + ADDR_SIZE'(1);
                        end
`endif
                    end
                    CMD_RD_ADDR: begin
                        rd_addr     <= addr_field;
                        rd_addr_set <= 1'b1;
                    end
                    CMD_RD_DATA: begin
                        tx_valid <= rd_addr_set;
                        cmd_err  <= !rd_addr_set;
`ifdef SPI_RAM_AUTOINC_EN
                        if (rd_addr_set) begin
                            rd_addr <= rd_addr + ADDR_SIZE'(1);
                        end
`endif
                    end
                endcase
            end
        end
    end

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wr_addr),
        .wdata (din[7:0]),
        .re    (mem_re),
        .raddr (rd_addr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_spi_ram.sv
// Scoreboard bench for spi_ram: a behavioural model queues expected pulses, a monitor checks them.
module tb_spi_ram;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    spi_ram dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       at;
        bit       is_tx;
        bit       chk_data;
        bit [7:0] data;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   done   = 0;

    // reference model state
    bit [7:0] mem_m   [256];
    bit       known_m [256];
    int       wa_m = 0, ra_m = 0;
    bit       wset_m = 0, rset_m = 0;
    bit [7:0] dout_m = 8'h00;
    bit       dout_known = 1;

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_cmd(input logic [9:0] w);
        exp_t e;
        e.at = cyc + 1;
        e.chk_data = 0;
        e.data = 8'h00;
        case (w[9:8])
            2'd0: begin wa_m = int'(w[7:0]); wset_m = 1; end
            2'd1: begin
                if (wset_m) begin
                    mem_m[wa_m] = w[7:0];
                    known_m[wa_m] = 1;
`ifdef SPI_RAM_AUTOINC_EN
                    wa_m = (wa_m + 1) % 256;
`endif
                end else begin
                    e.is_tx = 0;
                    q.push_back(e);
                end
            end
            2'd2: begin ra_m = int'(w[7:0]); rset_m = 1; end
            default: begin
                if (rset_m) begin
                    e.is_tx = 1;
                    e.chk_data = known_m[ra_m];
                    e.data = mem_m[ra_m];
                    dout_m = mem_m[ra_m];
                    dout_known = known_m[ra_m];
                    q.push_back(e);
`ifdef SPI_RAM_AUTOINC_EN
                    ra_m = (ra_m + 1) % 256;
`endif
                end else begin
                    e.is_tx = 0;
                    q.push_back(e);
                end
            end
        endcase
    endtask

    // Drive one command: rx_valid high for `hold` edges (din scrambled after the first), then low.
    task automatic send(input logic [9:0] w, input int hold, input bit scramble);
        @(negedge clk);
        din = w;
        rx_valid = 1'b1;
        model_cmd(w);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            if (scramble) din = 10'($urandom);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        din = 10'($urandom);
    endtask

    // Reset asserted immediately (takes effect at the next edge); model flags cleared, memory kept.
    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        while (q.size() > 0 && q[q.size()-1].at > cyc) void'(q.pop_back());
        wa_m = 0; ra_m = 0; wset_m = 0; rset_m = 0;
        dout_m = 8'h00; dout_known = 1;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx_valid"}, tx_valid == 1'b0, int'(tx_valid), 0);
        check({tag, "_cmd_err"}, cmd_err == 1'b0, int'(cmd_err), 0);
        if (dout_known) check({tag, "_dout"}, dout == dout_m, int'(dout), int'(dout_m));
    endtask

    always @(negedge clk) begin
        if (!done) begin
            while (q.size() > 0 && q[0].at < cyc) begin
                check(q[0].is_tx ? "missing_tx_valid" : "missing_cmd_err", 1'b0, 0, 1);
                void'(q.pop_front());
            end
            if (tx_valid || cmd_err) begin
                if (q.size() == 0 || q[0].at != cyc) begin
                    check("unexpected_pulse", 1'b0, {tx_valid, cmd_err}, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("pulse_tx_valid", tx_valid == e.is_tx, int'(tx_valid), int'(e.is_tx));
                    check("pulse_cmd_err", cmd_err == !e.is_tx, int'(cmd_err), int'(!e.is_tx));
                    if (e.is_tx && e.chk_data)
                        check("read_dout", dout == e.data, int'(dout), int'(e.data));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) known_m[i] = 0;
        repeat (3) @(negedge clk);
        do_reset(1);
        check_idle("reset");

        // basic write then read back
        send(10'h0_3C, 1, 0);
        send(10'h1_A5, 1, 0);
        send(10'h2_3C, 1, 0);
        send(10'h3_00, 1, 0);
        check("wr_rd_dout_held", dout == 8'hA5, int'(dout), 8'hA5);

        // seed address 0, then a data write without a write address must be rejected
        send(10'h0_00, 1, 0);
        send(10'h1_5A, 1, 0);
        do_reset(2);
        send(10'h1_55, 1, 0);
        send(10'h0_00, 1, 0);
        send(10'h2_00, 1, 0);
        send(10'h3_00, 1, 0);
        check("no_write_on_err", dout == 8'h5A, int'(dout), 8'h5A);

        // read with no read address
        do_reset(1);
        send(10'h3_00, 1, 0);
        check("rd_err_dout_zero", dout == 8'h00, int'(dout), 0);
        repeat (2) @(negedge clk);
        check_idle("after_rd_err");

        // rx_valid held high five cycles: exactly one command
        send(10'h0_10, 1, 0);
        send(10'h1_77, 5, 0);
        send(10'h2_10, 1, 0);
        send(10'h3_00, 3, 0);
        check("held_write_dout", dout == 8'h77, int'(dout), 8'h77);

        // reset right after an RD_DATA accept
        send(10'h0_20, 1, 0);
        send(10'h1_99, 1, 0);
        send(10'h2_20, 1, 0);
        send(10'h3_00, 1, 0);
        do_reset(1);
        check("mid_reset_tx_valid", tx_valid == 1'b0, int'(tx_valid), 0);
        check("mid_reset_dout", dout == 8'h00, int'(dout), 0);
        send(10'h3_00, 1, 0);

`ifdef SPI_RAM_AUTOINC_EN
        do_reset(1);
        send(10'h0_FF, 1, 0);
        send(10'h1_11, 1, 0);
        send(10'h1_22, 1, 0);
        send(10'h2_FF, 1, 0);
        send(10'h3_00, 1, 0);
        check("autoinc_first", dout == 8'h11, int'(dout), 8'h11);
        send(10'h3_00, 1, 0);
        check("autoinc_wrap", dout == 8'h22, int'(dout), 8'h22);
`endif

        // randomized traffic over a small address window so reads usually hit written bytes
        for (int n = 0; n < 400; n++) begin
            logic [9:0] w;
            logic [1:0] c;
            c = 2'($urandom_range(0, 3));
            if (c[1:0] == 2'd0 || c[1:0] == 2'd2)
                w = {c, 8'($urandom_range(0, 7))};
            else
                w = {c, 8'($urandom)};
            send(w, int'($urandom_range(1, 3)), 1);
            if ($urandom_range(0, 60) == 0) begin
                do_reset(1);
            end
        end

        repeat (4) @(negedge clk);
        check_idle("final");
        check("queue_drained", q.size() == 0, q.size(), 0);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram.md
Name: spi_ram

Overview:
- Single-port byte-wide memory sitting directly downstream of the SPI slave.
- Consumes the slave's 10-bit command words (rx_data/rx_valid) and decodes din[9:8] as a command.
- Holds separate write and read address registers.
- Returns read data to the slave on dout/tx_valid for serialisation onto MISO.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8, address width; legal range 1..8; the address is taken from din[ADDR_SIZE-1:0].

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- din  in  10  command word from SPI slave; [9:8] command, [7:0] payload.
- rx_valid  in  1  command word valid; level may be held for several cycles.
- dout  out  8  read data to SPI slave.
- tx_valid  out  1  one-cycle pulse: dout holds new read data.
- cmd_err  out  1  one-cycle pulse: rejected command.

Behaviour:
- Reset (rst_n=0 at posedge) sets:
  - dout=0, tx_valid=0, cmd_err=0.
  - wr_addr=0, rd_addr=0.
  - wr_addr_set=0, rd_addr_set=0.
  - rx_valid_q=0.
  - Memory array is NOT reset; contents are undefined until written.
- Acceptance:
  - A command is accepted only at a posedge where rx_valid=1 and rx_valid_q=0 (rising edge); rx_valid_q <= rx_valid every cycle.
  - rx_valid held high for N cycles yields exactly one command.
  - Consecutive commands need rx_valid low for at least one cycle between them.
- Decode of an accepted din[9:8]:
  - 00 WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0]; wr_addr_set <= 1.
  - 01 WR_DATA: if wr_addr_set, mem[wr_addr] <= din[7:0]; else no write, cmd_err=1 next cycle.
  - 10 RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0]; rd_addr_set <= 1.
  - 11 RD_DATA: if rd_addr_set, dout <= mem[rd_addr] and tx_valid=1 for exactly the following cycle; else cmd_err=1, dout holds, tx_valid stays 0. din[7:0] is ignored.
- Latency: dout/tx_valid are valid in the cycle after the accepting edge (1 clk).
- Outputs:
  - tx_valid and cmd_err are 0 in every cycle not immediately following an accepting edge.
  - dout holds its last value between reads.
- Address flags are never cleared except by reset; an address remains in use for repeated data commands.
- Read-after-write to the same address in a later command returns the newly written byte. One command per edge, so there are no same-cycle write/read collisions.
- Reset mid-operation: any pending tx_valid/cmd_err pulse is cancelled; a held rx_valid after reset release counts as a new rising edge only if it is first sampled low.

Optional Feature:
- Macro SPI_RAM_AUTOINC_EN.
- When defined:
  - Each accepted WR_DATA that writes increments wr_addr modulo MEM_DEPTH (MEM_DEPTH-1 wraps to 0).
  - Each successful RD_DATA increments rd_addr modulo MEM_DEPTH.
  - Rejected commands do not increment.
- When undefined: addresses change only on WR_ADDR/RD_ADDR.

Decomposition:
- Package spi_ram_pkg:
  - Command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - Field positions CMD_MSB=9, CMD_LSB=8.
- Sub-module spi_ram_array: MEM_DEPTH x 8 storage with synchronous write enable and registered read; keeps the inference-friendly memory separate from the decode/handshake logic.

Test Plan:
- Reset, then din=10'h0_3C (WR_ADDR 0x3C) edge, din=10'h1_A5 edge, din=10'h2_3C edge, din=10'h3_00 edge -> tx_valid pulses once, one cycle after the last edge, with dout=8'hA5.
- After reset, din=10'h1_55 edge (no write address) -> cmd_err one-cycle pulse, no memory write; later WR_ADDR 0x00 then RD 0x00 shows no 0x55.
- After reset, RD_DATA (din=10'h3_00) with no read address -> cmd_err pulse, tx_valid=0, dout stays 8'h00.
- rx_valid held high 5 cycles with din=10'h1_77 after WR_ADDR 0x10 -> exactly one write; a later read of 0x10 gives 0x77 with a single tx_valid pulse.
- Reset asserted the cycle after an RD_DATA accept -> tx_valid=0 and dout=0 after the reset edge; address flags cleared (next RD_DATA gives cmd_err).
- SPI_RAM_AUTOINC_EN defined: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; RD_ADDR 0xFF, RD_DATA x2 -> dout 0x11 then 0x22 (address wraps to 0x00).
